// File: rtl/arbiter_req_queue.sv
// arbiter_req_queue: two per-port command FIFOs that request a round-robin arbiter and forward granted words downstream.
module arbiter_req_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_1,
    input  logic [DATA_W-1:0] in_data_1,
    output logic              in_ready_1,
    input  logic              in_valid_2,
    input  logic [DATA_W-1:0] in_data_2,
    output logic              in_ready_2,
    output logic              req_1,
    output logic              req_2,
    input  logic              grant_1,
    input  logic              grant_2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              proto_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, CHECK} state_e;

    logic                   run_q;
    logic [1:0]             valid, gnt, ready, push, pop, req, in_check;
    logic [1:0][DATA_W-1:0] wdata, head;
    logic                   out_valid_q, out_src_q, proto_err_q;
    logic [DATA_W-1:0]      out_data_q;

    assign valid = {in_valid_2, in_valid_1};
    assign wdata = {in_data_2, in_data_1};
    // port 1 wins a simultaneous grant; port 2 then behaves as if it lost
    assign gnt   = {grant_2 & ~grant_1, grant_1};

    // held low for the first edge after release so no FSM leaves IDLE then
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) run_q <= 1'b0;
        else          run_q <= 1'b1;

    for (genvar g = 0; g < 2; g++) begin : g_port
        state_e            state_q, state_d;
        logic [AW:0]       count_q;
        logic [AW-1:0]     rd_q, wr_q;
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic              req_l;

        assign ready[g]    = count_q < (AW+1)'(DEPTH);
        assign push[g]     = valid[g] & ready[g];
        assign in_check[g] = state_q == CHECK;
        assign pop[g]      = in_check[g] & gnt[g];
        assign head[g]     = mem_q[rd_q];
        assign req[g]      = req_l;

        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) state_q <= IDLE;
            else          state_q <= state_d;

        always_comb begin
            state_d = IDLE;
            state_d = (state_q == IDLE)  ? ((run_q && count_q != '0) ? REQ : IDLE) :
                      (state_q == REQ)   ? CHECK :
                      (state_q == CHECK) ? ((pop[g] && count_q <= (AW+1)'(1)) ? IDLE : REQ) :
                                           IDLE;
        end

        always_comb req_l = state_q == REQ;

        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                count_q <= '0;
                rd_q    <= '0;
                wr_q    <= '0;
            end else begin
                count_q <= count_q + (AW+1)'(push[g]) - (AW+1)'(pop[g]);
                rd_q    <= rd_q + AW'(pop[g]);
                wr_q    <= wr_q + AW'(push[g]);
            end

        always_ff @(posedge clk)
            if (push[g]) mem_q[wr_q] <= wdata[g];
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            out_valid_q <= |pop;
            out_data_q  <= pop[0] ? head[0] : pop[1] ? head[1] : out_data_q;
            out_src_q   <= pop[1];
            proto_err_q <= proto_err_q | (grant_1 & ~in_check[0]) |
                           (grant_2 & ~in_check[1]) | (grant_1 & grant_2);
        end

    assign in_ready_1 = ready[0];
    assign in_ready_2 = ready[1];
    assign req_1      = req[0];
    assign req_2      = req[1];
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_arbiter_req_queue.sv
// tb_arbiter_req_queue: directed vector table plus hand sequences for fill, wrap, protocol errors and reset.
module tb_arbiter_req_queue;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid_1 = 1'b0, in_valid_2 = 1'b0;
    logic [7:0] in_data_1 = '0, in_data_2 = '0;
    logic       grant_1 = 1'b0, grant_2 = 1'b0;
    logic       in_ready_1, in_ready_2, req_1, req_2, out_valid, out_src, proto_err;
    logic [7:0] out_data;
    int         passed = 0, total = 0;

    arbiter_req_queue #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid_1(in_valid_1), .in_data_1(in_data_1), .in_ready_1(in_ready_1),
        .in_valid_2(in_valid_2), .in_data_2(in_data_2), .in_ready_2(in_ready_2),
        .req_1(req_1), .req_2(req_2), .grant_1(grant_1), .grant_2(grant_2),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v1; logic [7:0] d1; logic v2; logic [7:0] d2; logic g1, g2;
        logic       ov; logic [7:0] od; logic os; logic r1, r2;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid_1 = 0; in_valid_2 = 0; grant_1 = 0; grant_2 = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_req(input int p);
        int n = 0;
        while ((p == 1 ? req_1 : req_2) !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_wait", 32'(n < 20), 1);
    endtask

    task automatic pop_expect(input int p, input logic [7:0] exp);
        idle();
        wait_req(p);
        step();
        if (p == 1) grant_1 = 1; else grant_2 = 1;
        step();
        idle();
        chk("pop_valid", 32'(out_valid), 1);
        chk("pop_data", 32'(out_data), 32'(exp));
        chk("pop_src", 32'(out_src), 32'(p - 1));
    endtask

    task automatic do_reset();
        reset_n = 0;
        step(); step();
        reset_n = 1;
        step(); step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        logic [3:0] reqs;
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        step(); step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_req", 32'({req_1, req_2}), 0);
        chk("rst_ready", 32'({in_ready_1, in_ready_2}), 3);
        chk("rst_proto_err", 32'(proto_err), 0);
        reset_n = 1;
        step(); step();

        // single grant latency, then loss/re-request between the two ports
        for (int i = 0; i < 12; i++) begin
            in_valid_1 = tbl[i].v1; in_data_1 = tbl[i].d1;
            in_valid_2 = tbl[i].v2; in_data_2 = tbl[i].d2;
            grant_1 = tbl[i].g1; grant_2 = tbl[i].g2;
            step();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
                chk($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(tbl[i].os));
            end
            chk($sformatf("vec%0d_req_1", i), 32'(req_1), 32'(tbl[i].r1));
            chk($sformatf("vec%0d_req_2", i), 32'(req_2), 32'(tbl[i].r2));
            chk($sformatf("vec%0d_ready", i), 32'({in_ready_1, in_ready_2}), 3);
            chk($sformatf("vec%0d_proto_err", i), 32'(proto_err), 0);
        end
        idle();

        // fill port 2 without grants
        for (int k = 1; k <= 4; k++) begin
            in_valid_2 = 1; in_data_2 = 8'(k);
            step();
            reqs[k-1] = req_2;
        end
        chk("fill_req_pattern", 32'(reqs), 32'(4'b1010));
        chk("fill_ready_low", 32'(in_ready_2), 0);
        in_data_2 = 8'h05;
        step();
        idle();
        chk("fill_reject_req", 32'(req_2), 0);
        chk("fill_reject_ready", 32'(in_ready_2), 0);
        for (int k = 1; k <= 4; k++) pop_expect(2, 8'(k));
        step(); step();
        chk("fill_drained_ready", 32'(in_ready_2), 1);
        chk("fill_drained_valid", 32'(out_valid), 0);

        // port 1 full, push offered with the pop, then ordering across wrap
        for (int k = 0; k < 4; k++) begin
            in_valid_1 = 1; in_data_1 = 8'hB1 + 8'(k);
            step();
        end
        idle();
        chk("full_ready_low", 32'(in_ready_1), 0);
        wait_req(1);
        step();
        grant_1 = 1; in_valid_1 = 1; in_data_1 = 8'hB5;
        chk("full_ready_at_pop", 32'(in_ready_1), 0);
        step();
        idle();
        chk("full_pop_valid", 32'(out_valid), 1);
        chk("full_pop_data", 32'(out_data), 32'h B1);
        chk("full_ready_after_pop", 32'(in_ready_1), 1);
        in_valid_1 = 1; in_data_1 = 8'hB6;
        step();
        idle();
        chk("refill_ready_low", 32'(in_ready_1), 0);
        pop_expect(1, 8'hB2);
        pop_expect(1, 8'hB3);
        pop_expect(1, 8'hB4);
        pop_expect(1, 8'hB6);

        // push and pop on the same edge with one entry queued
        in_valid_1 = 1; in_data_1 = 8'hE1;
        step();
        idle();
        wait_req(1);
        step();
        grant_1 = 1; in_valid_1 = 1; in_data_1 = 8'hE2;
        step();
        idle();
        chk("pushpop_data", 32'(out_data), 32'h E1);
        chk("pushpop_ready", 32'(in_ready_1), 1);
        pop_expect(1, 8'hE2);
        step(); step();

        // grant to an idle port
        chk("perr_clean", 32'(proto_err), 0);
        grant_2 = 1;
        step();
        idle();
        chk("perr_idle_grant", 32'(proto_err), 1);
        chk("perr_idle_no_pop", 32'(out_valid), 0);
        step(); step();
        chk("perr_sticky", 32'(proto_err), 1);

        // simultaneous grants
        do_reset();
        chk("perr_cleared", 32'(proto_err), 0);
        in_valid_1 = 1; in_data_1 = 8'hC1; in_valid_2 = 1; in_data_2 = 8'hC2;
        step();
        idle();
        step();
        chk("dual_req", 32'({req_1, req_2}), 3);
        step();
        grant_1 = 1; grant_2 = 1;
        step();
        idle();
        chk("dual_valid", 32'(out_valid), 1);
        chk("dual_data", 32'(out_data), 32'h C1);
        chk("dual_src", 32'(out_src), 0);
        chk("dual_perr", 32'(proto_err), 1);
        pop_expect(2, 8'hC2);
        chk("dual_perr_held", 32'(proto_err), 1);

        // reset mid-operation
        for (int k = 0; k < 3; k++) begin
            in_valid_1 = 1; in_data_1 = 8'hD1 + 8'(k);
            step();
        end
        idle();
        wait_req(1);
        chk("pre_reset_req", 32'(req_1), 1);
        reset_n = 0;
        #1;
        chk("async_req", 32'({req_1, req_2}), 0);
        chk("async_valid", 32'(out_valid), 0);
        chk("async_data", 32'(out_data), 0);
        chk("async_src", 32'(out_src), 0);
        chk("async_perr", 32'(proto_err), 0);
        chk("async_ready", 32'({in_ready_1, in_ready_2}), 3);
        step(); step();
        reset_n = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("post_reset_quiet%0d", k), 32'({out_valid, req_1, req_2}), 0);
        end

        // grant in the first cycle after release
        reset_n = 0;
        step();
        reset_n = 1;
        grant_1 = 1;
        step();
        idle();
        chk("release_grant_perr", 32'(proto_err), 1);
        chk("release_grant_no_pop", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
